// File: rtl/menu_text_overlay.sv
// menu_text_overlay: 3-cycle pipelined text overlay over a 128x256 px window, driving external char/font ROMs.
// Optional macro TEXT_BG_EN paints non-glyph window pixels in BG_COLOR (opaque text box).
module menu_text_overlay #(
    parameter logic [10:0] X_POS      = 11'd448,
    parameter logic [10:0] Y_POS      = 11'd500,
    parameter logic [11:0] TEXT_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR   = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] in_hcount,
    input  logic [10:0] in_vcount,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_hblnk,
    input  logic        in_vblnk,
    input  logic [11:0] in_rgb,
    output logic [7:0]  char_xy,
    output logic [3:0]  char_line,
    input  logic [7:0]  char_line_pixels,
    output logic [10:0] out_hcount,
    output logic [10:0] out_vcount,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_hblnk,
    output logic        out_vblnk,
    output logic [11:0] out_rgb
);
`ifdef TEXT_BG_EN
    localparam logic BG_EN = 1'b1;
`else
    localparam logic BG_EN = 1'b0;
`endif
    logic [10:0] rel_x, rel_y;
    logic        in_win;
    logic [41:0] s1, s2;
    logic        win_d2, pix;
    logic [2:0]  bx_d2;
    logic [11:0] rgb_d2, next_rgb;
    // Unsigned wrap makes rel < size equivalent to the two-sided window compare.
    always_comb begin
        rel_x  = in_hcount - X_POS;
        rel_y  = in_vcount - Y_POS;
        in_win = !in_hblnk && !in_vblnk && (rel_x < 11'd128) && (rel_y < 11'd256);
    end
    assign char_xy   = {rel_y[7:4], rel_x[6:3]};
    assign char_line = rel_y[3:0];
    assign win_d2    = s2[41];
    assign bx_d2     = s2[40:38];
    assign rgb_d2    = s2[11:0];
    assign pix       = char_line_pixels[3'd7 - bx_d2];
    assign next_rgb  = (win_d2 && pix) ? TEXT_COLOR : (win_d2 && BG_EN) ? BG_COLOR : rgb_d2;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
            {out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, out_rgb} <= '0;
        end else begin
            s1 <= {in_win, rel_x[2:0], in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk, in_rgb};
            s2 <= s1;
            {out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk} <= s2[37:12];
            out_rgb <= next_rgb;
        end
    end
endmodule

// File: tb/tb_menu_text_overlay.sv
// tb_menu_text_overlay: directed checks of ROM addressing, glyph painting, window edges, reset and 3-cycle latency.
module tb_menu_text_overlay;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] in_hcount = '0, in_vcount = '0;
    logic        in_hsync = 1'b0, in_vsync = 1'b0, in_hblnk = 1'b0, in_vblnk = 1'b0;
    logic [11:0] in_rgb = '0;
    logic [7:0]  char_xy;
    logic [3:0]  char_line;
    logic [7:0]  char_line_pixels = '0;
    logic [10:0] out_hcount, out_vcount;
    logic        out_hsync, out_vsync, out_hblnk, out_vblnk;
    logic [11:0] out_rgb;
    int total = 0, bad = 0;
    logic [37:0] q[$];
`ifdef TEXT_BG_EN
    localparam logic [11:0] BGX = 12'h000;
`else
    localparam logic [11:0] BGX = 12'h0AB;
`endif

    menu_text_overlay dut (
        .clk(clk), .rst(rst),
        .in_hcount(in_hcount), .in_vcount(in_vcount),
        .in_hsync(in_hsync), .in_vsync(in_vsync),
        .in_hblnk(in_hblnk), .in_vblnk(in_vblnk), .in_rgb(in_rgb),
        .char_xy(char_xy), .char_line(char_line), .char_line_pixels(char_line_pixels),
        .out_hcount(out_hcount), .out_vcount(out_vcount),
        .out_hsync(out_hsync), .out_vsync(out_vsync),
        .out_hblnk(out_hblnk), .out_vblnk(out_vblnk), .out_rgb(out_rgb)
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] outs();
        return {out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, out_rgb};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hb, input logic vb,
                         input logic [11:0] rgb);
        in_hcount = h; in_vcount = v; in_hblnk = hb; in_vblnk = vb; in_rgb = rgb;
        in_hsync = 1'b0; in_vsync = 1'b0;
    endtask

    // Hold a pixel and font row steady, then read out_rgb after 3 edges.
    task automatic px(input string tag, input logic [10:0] h, input logic [10:0] v, input logic hb,
                      input logic vb, input logic [11:0] rgb, input logic [7:0] pixels, input logic [11:0] exp);
        drive(h, v, hb, vb, rgb);
        char_line_pixels = pixels;
        repeat (3) tick();
        chk(tag, 64'(out_rgb), 64'(exp));
    endtask

    // Raster-like stream outside the window; every output is compared against the input from 3 cycles earlier.
    task automatic stream(input string tag, input int n, input int h0, input int v0, input bit zero_first);
        int h, v;
        logic [37:0] cur;
        h = h0; v = v0;
        q.delete();
        char_line_pixels = 8'hFF;
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            if (q.size() >= 3) chk(tag, 64'(outs()), 64'(q[q.size()-3]));
            else if (zero_first) chk({tag, "_zero"}, 64'(outs()), 64'd0);
            cur = {11'(h), 11'(v), (h >= 1048 && h < 1184), (v >= 771 && v < 777), (h >= 1024), (v >= 768), 12'(i * 37 + 5)};
            {in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk, in_rgb} = cur;
            q.push_back(cur);
            h++;
            if (h == 1344) begin h = 0; v = (v == 805) ? 0 : v + 1; end
        end
    endtask

    initial begin
        drive(11'd100, 11'd200, 1'b0, 1'b0, 12'h5A5);
        in_hsync = 1'b1;
        repeat (2) tick();
        chk("reset_rgb", 64'(out_rgb), 64'd0);
        chk("reset_all", 64'(outs()), 64'd0);
        rst = 1'b1;
        drive(11'd448, 11'd500, 1'b0, 1'b0, 12'h123);
        #1 chk("xy_origin", 64'({char_xy, char_line}), 64'h000);
        drive(11'd455, 11'd517, 1'b0, 1'b0, 12'h123);
        #1 chk("xy_row1", 64'({char_xy, char_line}), 64'h101);
        drive(11'd575, 11'd755, 1'b0, 1'b0, 12'h123);
        #1 chk("xy_last", 64'({char_xy, char_line}), 64'hFFF);
        tick();
        px("glyph_bx0",  11'd448, 11'd500, 1'b0, 1'b0, 12'h123, 8'h80, 12'hFFF);
        px("blank_bx1",  11'd449, 11'd500, 1'b0, 1'b0, 12'h123, 8'h80, 12'h123);
        px("glyph_bx1",  11'd449, 11'd500, 1'b0, 1'b0, 12'h123, 8'h40, 12'hFFF);
        px("glyph_last", 11'd575, 11'd755, 1'b0, 1'b0, 12'h123, 8'h01, 12'hFFF);
        px("left_out",   11'd447, 11'd600, 1'b0, 1'b0, 12'h123, 8'hFF, 12'h123);
        px("right_out",  11'd576, 11'd600, 1'b0, 1'b0, 12'h123, 8'hFF, 12'h123);
        px("top_out",    11'd500, 11'd499, 1'b0, 1'b0, 12'h123, 8'hFF, 12'h123);
        px("bottom_out", 11'd500, 11'd756, 1'b0, 1'b0, 12'h123, 8'hFF, 12'h123);
        px("hblnk",      11'd500, 11'd600, 1'b1, 1'b0, 12'h123, 8'hFF, 12'h123);
        px("vblnk",      11'd500, 11'd600, 1'b0, 1'b1, 12'h123, 8'hFF, 12'h123);
        px("bg_pixel",   11'd450, 11'd600, 1'b0, 1'b0, 12'h0AB, 8'h80, BGX);
        // One-cycle window pixel; font row is only valid in the cycle before the third edge.
        drive(11'd100, 11'd400, 1'b0, 1'b0, 12'h456); char_line_pixels = 8'h00;
        tick();
        drive(11'd448, 11'd500, 1'b0, 1'b0, 12'h123);
        tick();
        drive(11'd100, 11'd400, 1'b0, 1'b0, 12'h789);
        tick();
        chk("pulse_pre", 64'(out_rgb), 64'h456);
        char_line_pixels = 8'h80;
        tick();
        char_line_pixels = 8'h00;
        chk("pulse_hit", 64'(out_rgb), 64'hFFF);
        tick();
        chk("pulse_post", 64'(out_rgb), 64'h789);
        stream("stream", 3000, 0, 0, 1'b0);
        rst = 1'b0;
        #1 chk("async_reset", 64'(outs()), 64'd0);
        repeat (2) tick();
        chk("held_reset", 64'(outs()), 64'd0);
        rst = 1'b1;
        stream("recover", 40, 1320, 770, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
